// File: rtl/trig_pkg.sv
// Shared types for the trigger timestamp block: record type codes, FSM states
// and the record width helper.
package trig_pkg;

  typedef enum logic [1:0] {
    REC_TRIG       = 2'd0,
    REC_TRIG_FIRST = 2'd1,
    REC_SPILL_END  = 2'd2
  } rec_type_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SPILL = 1'b1
  } state_t;

  function automatic int rec_width(input int cntw);
    return cntw + 2;
  endfunction

endpackage

// File: rtl/trig_timestamp_if.sv
// Readout bus of the trigger record FIFO: pop request plus head record and flags.
interface trig_timestamp_if
  import trig_pkg::*;
#(
  parameter int W = rec_width(32)
);
  logic         rd_en;
  logic [W-1:0] dout;
  logic         empty;
  logic         full;

  modport master (output rd_en, input dout, input empty, input full);
  modport slave  (input rd_en, output dout, output empty, output full);
endinterface

// File: rtl/trig_fifo.sv
// First-word-fall-through FIFO; a write into a full FIFO is accepted only when
// a pop happens in the same cycle.
module trig_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_rd;
  logic             do_wr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);
  assign dout  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // NOTE: storage is deliberately not reset; dout is masked while empty so stale words never show.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/trig_timestamp.sv
// Trigger receiver: synchronizes the trigger line, timestamps rising edges,
// marks spill start/end from trigger gaps and queues records for readout.
module trig_timestamp
  import trig_pkg::*;
#(
  parameter int CNTW       = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int GAPLEN     = 200,
  parameter int LOSTW      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             trigger,
  trig_timestamp_if.slave  bus,
  output logic             in_spill,
  output logic [LOSTW-1:0] lost_cnt
);
  localparam int          RW       = rec_width(CNTW);
  localparam logic [15:0] GAP_LAST = 16'(GAPLEN - 1);

  logic            s1, s2, s3;
  logic            en_d;
  logic [CNTW-1:0] ts;
  logic [15:0]     gap, gap_nxt;
  state_t          state, state_nxt;
  rec_type_t       rec_type;
  logic            wr_req;
  logic            trig_edge;
  logic            en_rise;
  logic            drop;

  assign trig_edge = s2 & ~s3;
  assign en_rise   = enable & ~en_d;
  assign in_spill  = (state == SPILL);
  assign drop      = wr_req & bus.full & ~bus.rd_en;

  // Two-stage synchronizer for the asynchronous line; s3 is the edge-detect history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= trigger;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_d     <= 1'b0;
      ts       <= '0;
      state    <= IDLE;
      gap      <= '0;
      lost_cnt <= '0;
    end else begin
      en_d  <= enable;
      state <= state_nxt;
      gap   <= gap_nxt;
      if (en_rise)     ts <= '0;
      else if (enable) ts <= ts + 1'b1;
      if (en_rise)                        lost_cnt <= '0;
      else if (drop && lost_cnt != '1)    lost_cnt <= lost_cnt + 1'b1;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    gap_nxt   = gap;
    wr_req    = 1'b0;
    rec_type  = REC_TRIG;
    if (!enable || en_rise) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (trig_edge) begin
            wr_req    = 1'b1;
            rec_type  = REC_TRIG_FIRST;
            gap_nxt   = '0;
            state_nxt = SPILL;
          end
        end
        SPILL: begin
          // A trigger in the timeout cycle wins, so the spill simply continues.
          if (trig_edge) begin
            wr_req   = 1'b1;
            rec_type = REC_TRIG;
            gap_nxt  = '0;
          end else if (gap == GAP_LAST) begin
            wr_req    = 1'b1;
            rec_type  = REC_SPILL_END;
            state_nxt = IDLE;
          end else begin
            gap_nxt = gap + 16'd1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  trig_fifo #(
    .WIDTH(RW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .wr_en (wr_req),
    .din   ({rec_type, ts}),
    .rd_en (bus.rd_en),
    .dout  (bus.dout),
    .empty (bus.empty),
    .full  (bus.full)
  );

endmodule
